// File: rtl/accumulator_control_pkg.sv
// Shared definitions for the accumulator CPU controller: opcode encodings,
// ALU function selects, FSM states and the decoded control word.
package opcodes;

   localparam logic [3:0] NOP   = 4'd0;
   localparam logic [3:0] JMP   = 4'd1;
   localparam logic [3:0] JMPZ  = 4'd2;
   localparam logic [3:0] JMPNZ = 4'd3;
   localparam logic [3:0] LDA   = 4'd4;
   localparam logic [3:0] ADD   = 4'd5;
   localparam logic [3:0] SUB   = 4'd6;
   localparam logic [3:0] AND   = 4'd7;
   localparam logic [3:0] OR    = 4'd8;
   localparam logic [3:0] NOT   = 4'd9;
   localparam logic [3:0] LSL   = 4'd10;
   localparam logic [3:0] LSR   = 4'd11;
   localparam logic [3:0] STA   = 4'd15;

   typedef enum logic [3:0] {
      FnACC = 4'd0,
      FnMem = 4'd1,
      FnADD = 4'd2,
      FnSUB = 4'd3,
      FnAND = 4'd4,
      FnOR  = 4'd5,
      FnNOT = 4'd6,
      FnLSL = 4'd7,
      FnLSR = 4'd8
   } alu_functions_t;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      HALT    = 2'd2
   } ctrl_state_t;

   // EXECUTE-phase strobes before completion gating by the FSM.
   typedef struct packed {
      alu_functions_t alu_fn;
      logic           mem_read;
      logic           mem_write;
      logic           acc_load;
      logic           pc_load;
      logic           illegal;
   } ctrl_word_t;

endpackage

// File: rtl/accumulator_control_instr_decoder.sv
// Combinational opcode decode: maps Opcode and AccZero to the EXECUTE control
// word; opcodes 12-14 decode as illegal.
module instr_decoder
   import opcodes::*;
(
   input  logic [3:0] i_opcode,
   input  logic       i_acc_zero,
   output ctrl_word_t o_cw
);

   always_comb begin
      o_cw        = '0;
      o_cw.alu_fn = FnACC;
      case (i_opcode)
         NOP:   ;
         JMP:   o_cw.pc_load = 1'b1;
         JMPZ:  o_cw.pc_load = i_acc_zero;
         JMPNZ: o_cw.pc_load = ~i_acc_zero;
         LDA, ADD, SUB, AND, OR: begin
            o_cw.mem_read = 1'b1;
            o_cw.acc_load = 1'b1;
            case (i_opcode)
               LDA:     o_cw.alu_fn = FnMem;
               ADD:     o_cw.alu_fn = FnADD;
               SUB:     o_cw.alu_fn = FnSUB;
               AND:     o_cw.alu_fn = FnAND;
               default: o_cw.alu_fn = FnOR;
            endcase
         end
         NOT: begin
            o_cw.alu_fn   = FnNOT;
            o_cw.acc_load = 1'b1;
         end
         LSL: begin
            o_cw.alu_fn   = FnLSL;
            o_cw.acc_load = 1'b1;
         end
         LSR: begin
            o_cw.alu_fn   = FnLSR;
            o_cw.acc_load = 1'b1;
         end
         STA:   o_cw.mem_write = 1'b1;
         default: o_cw.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/accumulator_control.sv
// Instruction-sequencing FSM for the accumulator CPU. Define
// CONTROL_MEMREADY_EN to add the i_mem_ready port and stretch memory cycles.
//
// state   | meaning
// FETCH   | read instruction at PC into IR (only when i_run)
// EXECUTE | perform decoded opcode, retire on completion
// HALT    | illegal opcode seen; exit only via reset
module accumulator_control
   import opcodes::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_run,
   input  logic [3:0]       i_opcode,
   input  logic             i_acc_zero,
`ifdef CONTROL_MEMREADY_EN
   input  logic             i_mem_ready,
`endif
   output logic             o_addr_sel,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic             o_ir_load,
   output logic             o_pc_inc,
   output logic             o_pc_load,
   output logic             o_acc_load,
   output alu_functions_t   o_alu_fn,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_instr_count
);

   ctrl_state_t      r_state;
   ctrl_state_t      w_next_state;
   logic [CNT_W-1:0] r_instr_count;
   ctrl_word_t       w_cw;
   logic             w_mem_ok;
   logic             w_access;
   logic             w_retire;

   instr_decoder u_decoder (
      .i_opcode   (i_opcode),
      .i_acc_zero (i_acc_zero),
      .o_cw       (w_cw)
   );

`ifdef CONTROL_MEMREADY_EN
   assign w_mem_ok = i_mem_ready;
`else
   assign w_mem_ok = 1'b1;
`endif

   assign w_access = w_cw.mem_read | w_cw.mem_write;

   always_comb begin
      w_next_state = r_state;
      w_retire     = 1'b0;
      o_addr_sel   = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_ir_load    = 1'b0;
      o_pc_inc     = 1'b0;
      o_pc_load    = 1'b0;
      o_acc_load   = 1'b0;
      o_alu_fn     = FnACC;
      o_halted     = 1'b0;
      case (r_state)
         FETCH: begin
            if (i_run) begin
               o_mem_read = 1'b1;
               if (w_mem_ok) begin
                  o_ir_load    = 1'b1;
                  o_pc_inc     = 1'b1;
                  w_next_state = EXECUTE;
               end
            end
         end
         EXECUTE: begin
            if (w_cw.illegal) begin
               w_next_state = HALT;
            end else begin
               o_alu_fn    = w_cw.alu_fn;
               o_mem_read  = w_cw.mem_read;
               o_mem_write = w_cw.mem_write;
               o_addr_sel  = w_access;
               // Load strobes fire only in the cycle the access completes.
               if (!w_access || w_mem_ok) begin
                  o_acc_load   = w_cw.acc_load;
                  o_pc_load    = w_cw.pc_load;
                  w_retire     = 1'b1;
                  w_next_state = FETCH;
               end
            end
         end
         HALT: o_halted = 1'b1;
         default: w_next_state = FETCH;
      endcase
      // Reset must silence every strobe, even though FETCH would read with i_run high.
      if (i_reset) begin
         o_addr_sel  = 1'b0;
         o_mem_read  = 1'b0;
         o_mem_write = 1'b0;
         o_ir_load   = 1'b0;
         o_pc_inc    = 1'b0;
         o_pc_load   = 1'b0;
         o_acc_load  = 1'b0;
         o_alu_fn    = FnACC;
         o_halted    = 1'b0;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= FETCH;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_retire)
            r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_accumulator_control.sv
// Self-checking bench for accumulator_control: directed instruction sequences
// with a per-cycle scoreboard of expected strobe words.
module tb_accumulator_control;
   import opcodes::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             run;
   logic [3:0]       opcode;
   logic             acc_zero;
`ifdef CONTROL_MEMREADY_EN
   logic             mem_ready;
`endif
   logic             addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load, acc_load, halted;
   alu_functions_t   alu_fn;
   logic [CNT_W-1:0] instr_count;

   int               n_checks = 0;
   int               n_errs   = 0;
   logic [11:0]      sb_q[$];
   logic [CNT_W-1:0] exp_cnt  = '0;

   always #5 clk = ~clk;

   accumulator_control #(.CNT_W(CNT_W)) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_run         (run),
      .i_opcode      (opcode),
      .i_acc_zero    (acc_zero),
`ifdef CONTROL_MEMREADY_EN
      .i_mem_ready   (mem_ready),
`endif
      .o_addr_sel    (addr_sel),
      .o_mem_read    (mem_read),
      .o_mem_write   (mem_write),
      .o_ir_load     (ir_load),
      .o_pc_inc      (pc_inc),
      .o_pc_load     (pc_load),
      .o_acc_load    (acc_load),
      .o_alu_fn      (alu_fn),
      .o_halted      (halted),
      .o_instr_count (instr_count)
   );

   // {addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load, acc_load, halted, alu_fn}
   function automatic logic [11:0] sw(input logic as, input logic mr, input logic mw,
                                      input logic il, input logic pi, input logic pl,
                                      input logic al, input logic h, input logic [3:0] fn);
      return {as, mr, mw, il, pi, pl, al, h, fn};
   endfunction

   function automatic logic [11:0] dut_word();
      return {addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load, acc_load, halted,
              4'(alu_fn)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Called just after a rising edge: drive inputs, check strobes at the falling edge.
   task automatic cyc(input string tag, input logic r, input logic [3:0] op,
                      input logic az, input logic rdy, input logic [11:0] exp);
      logic [11:0] e;
      run      = r;
      opcode   = op;
      acc_zero = az;
`ifdef CONTROL_MEMREADY_EN
      mem_ready = rdy;
`else
      if (rdy) ;
`endif
      sb_q.push_back(exp);
      @(negedge clk);
      chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(tag, 32'(dut_word()), 32'(e));
      end
      @(posedge clk);
      #1;
   endtask

   logic [11:0] W_IDLE, W_FETCH, W_HALT, W_STA;

   task automatic instr(input string tag, input logic [3:0] op, input logic az,
                        input logic [11:0] exp_ex);
      cyc({tag, "_fetch"}, 1'b1, NOP, 1'b0, 1'b1, W_FETCH);
      cyc({tag, "_exec"}, 1'b1, op, az, 1'b1, exp_ex);
      exp_cnt = exp_cnt + 1'b1;
      chk({tag, "_count"}, 32'(instr_count), 32'(exp_cnt));
   endtask

   logic [3:0]  mop [5];
   logic [3:0]  mfn [5];
   logic [3:0]  sop [3];
   logic [3:0]  sfn [3];

   initial begin
      W_IDLE  = sw(0, 0, 0, 0, 0, 0, 0, 0, FnACC);
      W_FETCH = sw(0, 1, 0, 1, 1, 0, 0, 0, FnACC);
      W_HALT  = sw(0, 0, 0, 0, 0, 0, 0, 1, FnACC);
      W_STA   = sw(1, 0, 1, 0, 0, 0, 0, 0, FnACC);
      mop = '{LDA, ADD, SUB, AND, OR};
      mfn = '{FnMem, FnADD, FnSUB, FnAND, FnOR};
      sop = '{NOT, LSL, LSR};
      sfn = '{FnNOT, FnLSL, FnLSR};

      rst = 1'b1; run = 1'b1; opcode = NOP; acc_zero = 1'b0;
`ifdef CONTROL_MEMREADY_EN
      mem_ready = 1'b1;
`endif
      @(negedge clk);
      chk("reset_strobes", 32'(dut_word()), 32'(W_IDLE));
      chk("reset_count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      instr("nop0", NOP, 1'b0, W_IDLE);
      instr("nop1", NOP, 1'b0, W_IDLE);
      chk("two_nops_count", 32'(instr_count), 32'd2);

      // LDA of zero then JMPZ taken; LDA of nonzero then JMPZ not taken
      instr("lda_zero", LDA, 1'b1, sw(1, 1, 0, 0, 0, 0, 1, 0, FnMem));
      instr("jmpz_taken", JMPZ, 1'b1, sw(0, 0, 0, 0, 0, 1, 0, 0, FnACC));
      instr("lda_seven", LDA, 1'b1, sw(1, 1, 0, 0, 0, 0, 1, 0, FnMem));
      instr("jmpz_not", JMPZ, 1'b0, W_IDLE);
      instr("jmpnz_taken", JMPNZ, 1'b0, sw(0, 0, 0, 0, 0, 1, 0, 0, FnACC));
      instr("jmpnz_not", JMPNZ, 1'b1, W_IDLE);
      instr("jmp", JMP, 1'b0, sw(0, 0, 0, 0, 0, 1, 0, 0, FnACC));

      for (int i = 0; i < 5; i++)
         instr("mem_alu", mop[i], 1'b0, sw(1, 1, 0, 0, 0, 0, 1, 0, mfn[i]));
      for (int i = 0; i < 3; i++)
         instr("reg_alu", sop[i], 1'b1, sw(0, 0, 0, 0, 0, 0, 1, 0, sfn[i]));

      instr("sta", STA, 1'b0, W_STA);

      // Run low holds FETCH; Run dropped in EXECUTE still finishes the instruction
      cyc("run_low0", 1'b0, LDA, 1'b0, 1'b1, W_IDLE);
      cyc("run_low1", 1'b0, LDA, 1'b0, 1'b1, W_IDLE);
      cyc("run_fetch", 1'b1, NOP, 1'b0, 1'b1, W_FETCH);
      cyc("run_drop_exec", 1'b0, ADD, 1'b0, 1'b1, sw(1, 1, 0, 0, 0, 0, 1, 0, FnADD));
      exp_cnt = exp_cnt + 1'b1;
      chk("run_drop_count", 32'(instr_count), 32'(exp_cnt));
      cyc("run_drop_idle", 1'b0, NOP, 1'b0, 1'b1, W_IDLE);

      // 16 NOPs wrap the 4-bit counter through 15 -> 0
      for (int i = 0; i < 16; i++)
         instr("wrap_nop", NOP, 1'b0, W_IDLE);
      while (exp_cnt != '1)
         instr("to_max", NOP, 1'b0, W_IDLE);
      instr("wrap_to_zero", NOP, 1'b0, W_IDLE);
      chk("wrapped_zero", 32'(instr_count), 32'd0);
      instr("nop_after_wrap", NOP, 1'b0, W_IDLE);

`ifdef CONTROL_MEMREADY_EN
      // ADD with 3 fetch waits and 2 operand waits: 7 cycles total
      for (int i = 0; i < 3; i++)
         cyc("wait_fetch", 1'b1, NOP, 1'b0, 1'b0, sw(0, 1, 0, 0, 0, 0, 0, 0, FnACC));
      cyc("wait_fetch_done", 1'b1, NOP, 1'b0, 1'b1, W_FETCH);
      for (int i = 0; i < 2; i++)
         cyc("wait_exec", 1'b1, ADD, 1'b0, 1'b0, sw(1, 1, 0, 0, 0, 0, 0, 0, FnADD));
      chk("wait_count_hold", 32'(instr_count), 32'(exp_cnt));
      cyc("wait_exec_done", 1'b1, ADD, 1'b0, 1'b1, sw(1, 1, 0, 0, 0, 0, 1, 0, FnADD));
      exp_cnt = exp_cnt + 1'b1;
      chk("wait_count", 32'(instr_count), 32'(exp_cnt));
      cyc("wait_sta", 1'b1, NOP, 1'b0, 1'b1, W_FETCH);
      cyc("wait_sta_hold", 1'b1, STA, 1'b0, 1'b0, W_STA);
      cyc("wait_sta_done", 1'b1, STA, 1'b0, 1'b1, W_STA);
      exp_cnt = exp_cnt + 1'b1;
      chk("wait_sta_count", 32'(instr_count), 32'(exp_cnt));
`endif

      // Reset mid-EXECUTE of STA drops MemWrite at once and clears the count
      cyc("rst_sta_fetch", 1'b1, NOP, 1'b0, 1'b1, W_FETCH);
      opcode = STA;
      @(negedge clk);
      chk("rst_sta_write", 32'(dut_word()), 32'(W_STA));
      #1 rst = 1'b1;
      #1;
      chk("rst_sta_dropped", 32'(dut_word()), 32'(W_IDLE));
      chk("rst_sta_count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_cnt = '0;
      instr("post_rst_nop", NOP, 1'b0, W_IDLE);

      // Illegal opcode: EXECUTE with no strobes, then HALT regardless of Run
      cyc("ill_fetch", 1'b1, NOP, 1'b0, 1'b1, W_FETCH);
      cyc("ill_exec", 1'b1, 4'd13, 1'b0, 1'b1, W_IDLE);
      chk("ill_count", 32'(instr_count), 32'(exp_cnt));
      for (int i = 0; i < 20; i++)
         cyc("halt", 1'b1, (i % 2 == 0) ? LDA : 4'd13, 1'b0, 1'b1, W_HALT);
      chk("halt_count", 32'(instr_count), 32'(exp_cnt));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_cnt = '0;
      instr("after_halt_rst", NOP, 1'b0, W_IDLE);
      instr("ill12_precheck", LSR, 1'b0, sw(0, 0, 0, 0, 0, 0, 1, 0, FnLSR));
      cyc("ill12_fetch", 1'b1, NOP, 1'b0, 1'b1, W_FETCH);
      cyc("ill12_exec", 1'b1, 4'd12, 1'b0, 1'b1, W_IDLE);
      cyc("ill12_halt", 1'b0, NOP, 1'b0, 1'b1, W_HALT);
      chk("ill12_count", 32'(instr_count), 32'(exp_cnt));

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
